mpx_trace_capture: RTL and testbench
====================================

# mpx_trace_capture

Instruction-trace capture controller for the MPX core. It snoops the retire stream (valid, pc, opcode) and sequences a circular trace buffer through arm, trigger, post-trigger fill and readout. It sits beside the core's retire port alongside the simulation disassembler. A debug host or testbench drains the captured window oldest-first over a valid/ready port.

## Interface
Parameters:
- DEPTH_W, 6: log2 of buffer depth. DEPTH = 2^DEPTH_W entries, each 64 bits ({pc, opcode}).

Ports:
- clk_i  in  1  core clock; single clock domain.
- rst_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  retire strobe; one instruction retired this cycle.
- pc_i  in  32  PC of the retiring instruction.
- opcode_i  in  32  opcode of the retiring instruction.
- arm_i  in  1  single-cycle pulse; clears the buffer and starts a capture.
- post_count_i  in  DEPTH_W+1  entries to capture at/after the trigger; sampled on arm_i.
- trig_en_i  in  1  enables the PC-match trigger.
- trig_pc_i  in  32  trigger PC.
- trig_force_i  in  1  manual trigger pulse.
- rd_valid_o  out  1  readout entry available.
- rd_ready_i  in  1  readout accept.
- rd_pc_o  out  32  PC of the current readout entry.
- rd_opcode_o  out  32  opcode of the current readout entry.
- rd_last_o  out  1  current readout entry is the final one.
- state_o  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- triggered_o  out  1  a trigger has fired since the last arm.
- count_o  out  DEPTH_W+1  valid entries held, 0..DEPTH.

## Operation
- Reset: state IDLE. wr_ptr, rd_ptr, count, remaining and triggered all 0. All outputs 0. Buffer contents are don't-care.
- arm_i has the highest priority in every state:
  - count←0, triggered←0, state←ARMED.
  - P←min(post_count_i, DEPTH).
  - A valid_i in the same cycle is not captured. wr_ptr is not reset.
- Trigger event = trig_force_i OR (valid_i AND trig_en_i AND pc_i==trig_pc_i). It is only honoured in ARMED.
- IDLE: valid_i is ignored.
- ARMED, no trigger: every valid_i writes mem[wr_ptr]. wr_ptr increments modulo DEPTH. count saturates at DEPTH, so the oldest entry is overwritten.
- ARMED, trigger:
  - triggered←1.
  - If valid_i and P>0: the entry is written and remaining←P-1.
  - Otherwise nothing is written and remaining←P.
  - If remaining is then 0, go to DONE; else go to POST.
  - A forced trigger without valid_i still counts the trigger itself. With P=0, the triggering instruction is never stored.
- POST: each valid_i writes as in ARMED and decrements remaining. The write that brings remaining to 0 moves the state to DONE. Trigger inputs are ignored.
- DONE (readout):
  - On entry: rd_ptr←(wr_ptr−count) mod DEPTH, left←count.
  - rd_valid_o = (left≠0).
  - rd_pc_o/rd_opcode_o = mem[rd_ptr], read combinationally.
  - rd_last_o = (left==1).
  - On rd_valid_o AND rd_ready_i: rd_ptr++ (wraps), left--.
  - When left reaches 0: state←IDLE. If count was 0 on entry, go to IDLE on the next cycle.
  - valid_i and triggers are ignored in DONE.
- count_o holds its value through readout and IDLE until the next arm.

## Timing
- All state is registered on the rising edge of clk_i. Reset takes effect immediately on its falling edge and releases synchronously to the next edge.
- Capture is zero-latency: an entry is written on the edge where valid_i is high. count_o reflects it the following cycle.
- State change from trigger or last post write: state_o updates the cycle after the qualifying edge.
- rd_valid_o first asserts the cycle state_o==3 is visible, one cycle after the last capture.
- Readout sustains one entry per cycle with rd_ready_i held high. Data is stable while rd_valid_o is high and rd_ready_i is low.
- Back-to-back arm_i pulses: each restarts the capture. An arm during readout aborts it; rd_valid_o drops the next cycle.

## Test plan
- DEPTH_W=3, arm with post_count=3, trig_en=1, trig_pc=0x100. Retire PCs 0xF0,0xF4,…,0x100,0x104,0x108,0x10C.
  -> state goes to DONE after 0x108. Readout returns 0xF0..0x108 (7 entries), rd_last_o on 0x108, count_o=7.
- Same setup with 20 pre-trigger retires.
  -> count saturates at 8. Readout is the 5 newest pre-trigger entries, then 0x100, 0x104, 0x108, in order across the wrap.
- post_count=0, trig_force_i with no valid_i after 2 retires.
  -> DONE next cycle, readout of 2 entries, triggered_o=1.
- post_count=12 with DEPTH 8 -> clamped to 8. Readout begins at the trigger PC.
- Readout with rd_ready_i toggling 1,0,1,0.
  -> each entry is presented exactly once and held stable while not ready. Return to IDLE after the last handshake.
- Assert rst_i low during POST -> all outputs 0 immediately, state IDLE. valid_i is ignored until the next arm.

Source files
------------

// File: rtl/mpx_trace_capture.sv
// mpx_trace_capture: instruction-trace capture controller for the MPX core.
// Snoops the retire stream into a circular buffer, arms/triggers/fills the
// post-trigger window, then drains the captured window oldest-first.
//
// Ports:
//   clk_i, rst_i                 clock, async active-low reset
//   valid_i, pc_i, opcode_i      retire stream
//   arm_i, post_count_i          start capture, post-trigger length (sampled on arm)
//   trig_en_i, trig_pc_i         PC-match trigger
//   trig_force_i                 manual trigger
//   rd_valid_o, rd_ready_i       readout handshake
//   rd_pc_o, rd_opcode_o         current readout entry
//   rd_last_o                    current entry is the final one
//   state_o, triggered_o, count_o  status
module mpx_trace_capture #(
  parameter int unsigned DEPTH_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        opcode_i,
  input  logic               arm_i,
  input  logic [DEPTH_W:0]   post_count_i,
  input  logic               trig_en_i,
  input  logic [31:0]        trig_pc_i,
  input  logic               trig_force_i,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic [31:0]        rd_pc_o,
  output logic [31:0]        rd_opcode_o,
  output logic               rd_last_o,
  output logic [1:0]         state_o,
  output logic               triggered_o,
  output logic [DEPTH_W:0]   count_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;
  localparam int unsigned CW    = DEPTH_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DEPTH_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        remaining_q, remaining_d;
  logic [CW-1:0]        left_q, left_d;
  logic [CW-1:0]        post_len_q, post_len_d;
  logic                 triggered_q, triggered_d;

  logic [63:0]          mem [DEPTH];
  logic                 wr_en;
  logic                 trig;
  logic                 enter_done;
  logic                 rd_fire;
  logic [CW-1:0]        post_clamp;

  assign trig       = trig_force_i | (valid_i & trig_en_i & (pc_i == trig_pc_i));
  assign post_clamp = (post_count_i > CW'(DEPTH)) ? CW'(DEPTH) : post_count_i;
  assign rd_valid_o = (state_q == ST_DONE) && (left_q != '0);
  assign rd_fire    = rd_valid_o & rd_ready_i;

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    left_d      = left_q;
    post_len_d  = post_len_q;
    triggered_d = triggered_q;
    wr_en       = 1'b0;
    enter_done  = 1'b0;

    if (arm_i) begin
      state_d     = ST_ARMED;
      count_d     = '0;
      triggered_d = 1'b0;
      post_len_d  = post_clamp;
      left_d      = '0;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (trig) begin
            triggered_d = 1'b1;
            if (valid_i && (post_len_q != '0)) begin
              wr_en       = 1'b1;
              remaining_d = post_len_q - CW'(1);
            end else begin
              remaining_d = post_len_q;
            end
            if (remaining_d == '0) enter_done = 1'b1;
            else                   state_d    = ST_POST;
          end else if (valid_i) begin
            wr_en = 1'b1;
          end
        end
        ST_POST: begin
          if (valid_i) begin
            wr_en       = 1'b1;
            remaining_d = remaining_q - CW'(1);
            if (remaining_d == '0) enter_done = 1'b1;
          end
        end
        ST_DONE: begin
          if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + DEPTH_W'(1);
            left_d   = left_q - CW'(1);
            if (left_q == CW'(1)) state_d = ST_IDLE;
          end else if (left_q == '0) begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase

      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + DEPTH_W'(1);
        count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
      end

      // Readout starts at the oldest held entry; a full buffer wraps to wr_ptr.
      if (enter_done) begin
        state_d  = ST_DONE;
        rd_ptr_d = wr_ptr_d - count_d[DEPTH_W-1:0];
        left_d   = count_d;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      left_q      <= '0;
      post_len_q  <= '0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      left_q      <= left_d;
      post_len_q  <= post_len_d;
      triggered_q <= triggered_d;
    end
  end

  // Trace storage; contents need no reset
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= {pc_i, opcode_i};
  end

  // Data gated by rd_valid_o so outputs read 0 outside readout
  assign {rd_pc_o, rd_opcode_o} = rd_valid_o ? mem[rd_ptr_q] : 64'd0;
  assign rd_last_o   = rd_valid_o && (left_q == CW'(1));
  assign state_o     = state_q;
  assign triggered_o = triggered_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_mpx_trace_capture.sv
// Directed self-checking bench for mpx_trace_capture with an 8-entry buffer.
module tb_mpx_trace_capture;

  localparam int unsigned DW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [31:0]   pc_i;
  logic [31:0]   opcode_i;
  logic          arm_i;
  logic [DW:0]   post_count_i;
  logic          trig_en_i;
  logic [31:0]   trig_pc_i;
  logic          trig_force_i;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [31:0]   rd_pc_o;
  logic [31:0]   rd_opcode_o;
  logic          rd_last_o;
  logic [1:0]    state_o;
  logic          triggered_o;
  logic [DW:0]   count_o;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  mpx_trace_capture #(.DEPTH_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
    .opcode_i(opcode_i), .arm_i(arm_i), .post_count_i(post_count_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .trig_force_i(trig_force_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_pc_o(rd_pc_o),
    .rd_opcode_o(rd_opcode_o), .rd_last_o(rd_last_o), .state_o(state_o),
    .triggered_o(triggered_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] opc(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic arm(input int post);
    arm_i = 1'b1;
    post_count_i = (DW+1)'(post);
    cyc();
    arm_i = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc);
    valid_i = 1'b1;
    pc_i = pc;
    opcode_i = opc(pc);
    cyc();
    valid_i = 1'b0;
  endtask

  // Drains exp_q; toggle=1 drives ready 1,0,1,0...
  task automatic drain(input string tag, input bit toggle);
    int idx = 0;
    int n = exp_q.size();
    bit rdy;
    for (int k = 0; k < 64 && idx < n; k++) begin
      chk({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
      chk({tag, "_pc"}, rd_pc_o, exp_q[idx]);
      chk({tag, "_opc"}, rd_opcode_o, opc(exp_q[idx]));
      chk({tag, "_last"}, 32'(rd_last_o), 32'(idx == n - 1));
      rdy = toggle ? ((k % 2) == 0) : 1'b1;
      rd_ready_i = rdy;
      cyc();
      if (rdy) idx++;
    end
    rd_ready_i = 1'b0;
    chk({tag, "_done_cnt"}, 32'(idx), 32'(n));
    chk({tag, "_idle"}, 32'(state_o), 32'd0);
    chk({tag, "_valid_off"}, 32'(rd_valid_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; pc_i = '0; opcode_i = '0; arm_i = 1'b0;
    post_count_i = '0; trig_en_i = 1'b1; trig_pc_i = 32'h100;
    trig_force_i = 1'b0; rd_ready_i = 1'b0;
    cyc(); cyc();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_pc", rd_pc_o, 32'd0);
    chk("rst_trig", 32'(triggered_o), 32'd0);
    rst_i = 1'b1;
    cyc();

    // Basic capture: 4 pre, trigger, 2 post
    arm(3);
    chk("t1_armed", 32'(state_o), 32'd1);
    for (int i = 0; i < 4; i++) retire(32'hF0 + 32'(4 * i));
    chk("t1_pre_cnt", 32'(count_o), 32'd4);
    retire(32'h100);
    chk("t1_post", 32'(state_o), 32'd2);
    chk("t1_trig", 32'(triggered_o), 32'd1);
    retire(32'h104);
    chk("t1_still_post", 32'(state_o), 32'd2);
    retire(32'h108);
    chk("t1_done", 32'(state_o), 32'd3);
    chk("t1_cnt", 32'(count_o), 32'd7);
    retire(32'h10C);
    chk("t1_ign_cnt", 32'(count_o), 32'd7);
    chk("t1_hold_pc", rd_pc_o, 32'hF0);
    exp_q = {};
    for (int i = 0; i < 7; i++) exp_q.push_back(32'hF0 + 32'(4 * i));
    drain("t1", 1'b0);
    chk("t1_cnt_hold", 32'(count_o), 32'd7);

    // Saturation and wrap
    arm(3);
    for (int i = 0; i < 20; i++) retire(32'h1000 + 32'(4 * i));
    chk("t2_sat", 32'(count_o), 32'd8);
    chk("t2_notrig", 32'(triggered_o), 32'd0);
    retire(32'h100); retire(32'h104); retire(32'h108);
    chk("t2_done", 32'(state_o), 32'd3);
    exp_q = {};
    for (int i = 15; i < 20; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    drain("t2", 1'b0);

    // Arm with simultaneous valid is not captured; forced trigger, P=0
    valid_i = 1'b1; pc_i = 32'h500; opcode_i = opc(32'h500);
    arm(0);
    valid_i = 1'b0;
    chk("t3_arm_nocap", 32'(count_o), 32'd0);
    retire(32'h300); retire(32'h304);
    trig_force_i = 1'b1;
    cyc();
    trig_force_i = 1'b0;
    chk("t3_done", 32'(state_o), 32'd3);
    chk("t3_trig", 32'(triggered_o), 32'd1);
    chk("t3_cnt", 32'(count_o), 32'd2);
    exp_q = {32'h300, 32'h304};
    drain("t3", 1'b0);

    // P=0 with a PC-match trigger: triggering instruction not stored
    arm(0);
    retire(32'h700);
    retire(32'h100);
    chk("t4_done", 32'(state_o), 32'd3);
    chk("t4_cnt", 32'(count_o), 32'd1);
    exp_q = {32'h700};
    drain("t4", 1'b0);

    // post_count clamp to 8, readout with ready toggling
    arm(12);
    retire(32'h400); retire(32'h404);
    retire(32'h100);
    for (int i = 1; i < 7; i++) retire(32'h100 + 32'(4 * i));
    chk("t5_post", 32'(state_o), 32'd2);
    retire(32'h11C);
    chk("t5_done", 32'(state_o), 32'd3);
    chk("t5_cnt", 32'(count_o), 32'd8);
    exp_q = {};
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    drain("t5", 1'b1);

    // Arm during readout aborts it
    arm(0);
    retire(32'h800);
    trig_force_i = 1'b1; cyc(); trig_force_i = 1'b0;
    chk("t6_valid", 32'(rd_valid_o), 32'd1);
    arm(2);
    chk("t6_abort", 32'(rd_valid_o), 32'd0);
    chk("t6_armed", 32'(state_o), 32'd1);

    // Async reset during POST
    retire(32'h100);
    chk("t7_post", 32'(state_o), 32'd2);
    #2 rst_i = 1'b0;
    #1;
    chk("t7_rst_state", 32'(state_o), 32'd0);
    chk("t7_rst_cnt", 32'(count_o), 32'd0);
    chk("t7_rst_trig", 32'(triggered_o), 32'd0);
    chk("t7_rst_valid", 32'(rd_valid_o), 32'd0);
    cyc();
    rst_i = 1'b1;
    retire(32'h600); retire(32'h100);
    chk("t7_idle", 32'(state_o), 32'd0);
    chk("t7_idle_cnt", 32'(count_o), 32'd0);
    chk("t7_idle_trig", 32'(triggered_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
